// File: rtl/colour_pkg.sv
// rtl/colour_pkg.sv - shared constants, state encoding and helpers for the colour sensor blocks
package colour_pkg;

    // Sensor filter select codes (S2,S3 pins)
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_BLUE  = 2'b10;

    // Pulse count a white target produces in one calibrated window
    localparam int WHITE_COUNT = 255;

    // Each MEAS state directly follows its SETTLE state in this encoding
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE_R = 3'd1,
        ST_MEAS_R   = 3'd2,
        ST_SETTLE_G = 3'd3,
        ST_MEAS_G   = 3'd4,
        ST_SETTLE_B = 3'd5,
        ST_MEAS_B   = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    // Saturating increment for the 8-bit pulse counter
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'(WHITE_COUNT)) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// rtl/pulse_sync_edge.sv - two-flop synchroniser with registered rising-edge pulse
module pulse_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronise the raw input, remember the previous sample, and emit a one-cycle pulse on a rise
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            meta  <= din;
            sync  <= meta;
            prev  <= sync;
            pulse <= sync & ~prev;
        end
    end

endmodule

// File: rtl/color_measure.sv
// rtl/color_measure.sv - measures R/G/B pulse counts over calibrated windows of a frequency-output colour sensor
module color_measure
    import colour_pkg::*;
#(
    parameter int CNT_W      = 64,
    parameter int SETTLE_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             white_frequency,
    input  logic [CNT_W-1:0] para_red,
    input  logic [CNT_W-1:0] para_green,
    input  logic [CNT_W-1:0] para_blue,
    output logic [1:0]       filter_select,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] lat_r;
    logic [CNT_W-1:0] lat_g;
    logic [CNT_W-1:0] lat_b;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] win_cnt;
    logic [7:0]       pulse_cnt;
    logic [7:0]       stage_r;
    logic [7:0]       stage_g;

    logic             edge_pulse;
    logic [CNT_W-1:0] cur_para;
    logic [7:0]       pulse_next;
    logic [7:0]       chan_val;
    logic             in_settle;
    logic             in_meas;
    logic             settle_done;
    logic             win_done;
    logic             chan_end;

    pulse_sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (white_frequency),
        .pulse (edge_pulse)
    );

    // Select the active channel's window, and decide whether this cycle closes the channel
    always_comb begin
        cur_para = lat_r;
        case (state)
            ST_SETTLE_G, ST_MEAS_G: cur_para = lat_g;
            ST_SETTLE_B, ST_MEAS_B: cur_para = lat_b;
            default:                cur_para = lat_r;
        endcase
        in_settle   = (state == ST_SETTLE_R) || (state == ST_SETTLE_G) || (state == ST_SETTLE_B);
        in_meas     = (state == ST_MEAS_R) || (state == ST_MEAS_G) || (state == ST_MEAS_B);
        settle_done = (settle_cnt == SETTLE_LAST);
        // Equality against para-1 keeps any para value legal; para==0 never reaches MEAS
        win_done    = (win_cnt == cur_para - CNT_ONE);
        pulse_next  = edge_pulse ? sat_inc(pulse_cnt) : pulse_cnt;
        // A zero window closes the channel straight out of SETTLE with a zero result
        chan_end    = (in_settle && settle_done && (cur_para == '0)) || (in_meas && win_done);
        chan_val    = in_meas ? pulse_next : 8'd0;
    end

    // Measurement sequencer: settle, count, stage each channel, then publish all three together
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            lat_r         <= '0;
            lat_g         <= '0;
            lat_b         <= '0;
            settle_cnt    <= '0;
            win_cnt       <= '0;
            pulse_cnt     <= 8'd0;
            stage_r       <= 8'd0;
            stage_g       <= 8'd0;
            filter_select <= FILT_RED;
            red           <= 8'd0;
            green         <= 8'd0;
            blue          <= 8'd0;
            valid         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        lat_r         <= para_red;
                        lat_g         <= para_green;
                        lat_b         <= para_blue;
                        busy          <= 1'b1;
                        filter_select <= FILT_RED;
                        settle_cnt    <= '0;
                        win_cnt       <= '0;
                        pulse_cnt     <= 8'd0;
                        state         <= ST_SETTLE_R;
                    end
                end
                ST_SETTLE_R, ST_SETTLE_G, ST_SETTLE_B: begin
                    if (settle_done) begin
                        settle_cnt <= '0;
                        win_cnt    <= '0;
                        pulse_cnt  <= 8'd0;
                        // Advance to the matching MEAS state (next code in the encoding)
                        state      <= state_t'(state + 3'd1);
                    end else begin
                        settle_cnt <= settle_cnt + CNT_ONE;
                    end
                end
                ST_MEAS_R, ST_MEAS_G, ST_MEAS_B: begin
                    pulse_cnt <= pulse_next;
                    win_cnt   <= win_cnt + CNT_ONE;
                end
                ST_DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Channel close overrides the per-state updates above
            if (chan_end) begin
                pulse_cnt  <= 8'd0;
                win_cnt    <= '0;
                settle_cnt <= '0;
                case (state)
                    ST_SETTLE_R, ST_MEAS_R: begin
                        stage_r       <= chan_val;
                        filter_select <= FILT_GREEN;
                        state         <= ST_SETTLE_G;
                    end
                    ST_SETTLE_G, ST_MEAS_G: begin
                        stage_g       <= chan_val;
                        filter_select <= FILT_BLUE;
                        state         <= ST_SETTLE_B;
                    end
                    default: begin
                        red           <= stage_r;
                        green         <= stage_g;
                        blue          <= chan_val;
                        valid         <= 1'b1;
                        filter_select <= FILT_RED;
                        state         <= ST_DONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_color_measure.sv
// tb/tb_color_measure.sv - randomized self-checking bench for color_measure
module tb_color_measure;

    localparam int S     = 4;
    localparam int CNT_W = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             white_frequency = 1'b0;
    logic [CNT_W-1:0] para_red = '0;
    logic [CNT_W-1:0] para_green = '0;
    logic [CNT_W-1:0] para_blue = '0;
    logic [1:0]       filter_select;
    logic [7:0]       red;
    logic [7:0]       green;
    logic [7:0]       blue;
    logic             valid;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wave_period = 0;
    int rises[$];
    int exp_r = 0;
    int exp_g = 0;
    int exp_b = 0;

    color_measure #(.CNT_W(CNT_W), .SETTLE_CYC(S)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .white_frequency (white_frequency),
        .para_red        (para_red),
        .para_green      (para_green),
        .para_blue       (para_blue),
        .filter_select   (filter_select),
        .red             (red),
        .green           (green),
        .blue            (blue),
        .valid           (valid),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Square-wave sensor model; logs the cycle of every raw rise
    always @(negedge clk) begin : wave_gen
        logic nv;
        nv = (wave_period >= 2) && ((cyc % wave_period) < (wave_period / 2));
        if (nv && !white_frequency) rises.push_back(cyc);
        white_frequency = nv;
    end

    // Pulses that land inside a window: each raw rise becomes visible 3 cycles later
    function automatic int model_count(input int lo, input int len);
        int n;
        n = 0;
        foreach (rises[i]) begin
            if ((rises[i] + 3 >= lo) && (rises[i] + 3 < lo + len)) n++;
        end
        return (n > 255) ? 255 : n;
    endfunction

    // Run one measurement from the current negedge, checking every cycle against the window model
    task automatic watch(input string name, input int pr, input int pg, input int pb,
                         input bit disturb, input bit b2b);
        int m, lo_r, lo_g, lo_b, done, mid, last;
        logic [1:0] fexp;
        m          = cyc;
        para_red   = CNT_W'(pr);
        para_green = CNT_W'(pg);
        para_blue  = CNT_W'(pb);
        start      = 1'b1;
        rises.delete();
        lo_r = m + S + 1;
        lo_g = lo_r + pr + S;
        lo_b = lo_g + pg + S;
        done = lo_b + pb;
        mid  = lo_g + pg / 2;
        last = done + (b2b ? 1 : 2);
        for (int c = m + 1; c <= last; c++) begin
            @(negedge clk);
            if (c >= lo_r + pr && c < lo_g + pg)      fexp = 2'b11;
            else if (c >= lo_g + pg && c < done)      fexp = 2'b10;
            else                                      fexp = 2'b00;
            if (c == done) begin
                exp_r = model_count(lo_r, pr);
                exp_g = model_count(lo_g, pg);
                exp_b = model_count(lo_b, pb);
            end
            checks++;
            if (filter_select !== fexp) begin
                errors++;
                $display("FAIL %s filter_select at +%0d: got %b want %b", name, c - m, filter_select, fexp);
            end
            checks++;
            if (busy !== (c <= done)) begin
                errors++;
                $display("FAIL %s busy at +%0d: got %b want %b", name, c - m, busy, (c <= done));
            end
            checks++;
            if (valid !== (c == done)) begin
                errors++;
                $display("FAIL %s valid at +%0d: got %b want %b", name, c - m, valid, (c == done));
            end
            checks++;
            if (red !== 8'(exp_r) || green !== 8'(exp_g) || blue !== 8'(exp_b)) begin
                errors++;
                $display("FAIL %s rgb at +%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                         name, c - m, red, green, blue, exp_r, exp_g, exp_b);
            end
            start = (disturb && c == mid) || (b2b && c >= done);
            if (disturb && c == mid) begin
                para_red  = CNT_W'($urandom_range(1, 500));
                para_blue = CNT_W'($urandom_range(1, 500));
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (filter_select !== 2'b00 || busy !== 1'b0 || valid !== 1'b0 ||
            red !== 8'd0 || green !== 8'd0 || blue !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got f=%b busy=%b valid=%b rgb=%0d/%0d/%0d want f=00 busy=0 valid=0 rgb=0/0/0",
                     filter_select, busy, valid, red, green, blue);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: got busy=%b valid=%b want 0/0", busy, valid);
        end
    endtask

    task automatic test_square10();
        wave_period = 10;
        watch("square10", 100, 100, 100, 1'b0, 1'b0);
        checks++;
        if (red < 8'd9 || red > 8'd11 || green < 8'd9 || green > 8'd11 || blue < 8'd9 || blue > 8'd11) begin
            errors++;
            $display("FAIL square10_nominal: got %0d/%0d/%0d want 10+-1 each", red, green, blue);
        end
    endtask

    task automatic test_saturate();
        wave_period = 2;
        watch("saturate", 1000, 20, 0, 1'b0, 1'b0);
        checks++;
        if (red !== 8'd255 || green !== 8'd10 || blue !== 8'd0) begin
            errors++;
            $display("FAIL saturate_values: got %0d/%0d/%0d want 255/10/0", red, green, blue);
        end
    endtask

    task automatic test_dark();
        wave_period = 0;
        @(negedge clk);
        watch("dark", 50, 50, 50, 1'b0, 1'b0);
        checks++;
        if (red !== 8'd0 || green !== 8'd0 || blue !== 8'd0) begin
            errors++;
            $display("FAIL dark_values: got %0d/%0d/%0d want 0/0/0", red, green, blue);
        end
    endtask

    task automatic test_disturb();
        wave_period = 8;
        watch("disturb", 40, 60, 30, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        wave_period = 6;
        para_red   = CNT_W'(30);
        para_green = CNT_W'(30);
        para_blue  = CNT_W'(30);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * S + 34) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_r = 0;
        exp_g = 0;
        exp_b = 0;
        checks++;
        if (filter_select !== 2'b00 || busy !== 1'b0 || valid !== 1'b0 ||
            red !== 8'd0 || green !== 8'd0 || blue !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got f=%b busy=%b valid=%b rgb=%0d/%0d/%0d want 00/0/0/0",
                     filter_select, busy, valid, red, green, blue);
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet at +%0d: got valid=%b busy=%b want 0/0", i, valid, busy);
            end
        end
        watch("after_reset", 25, 35, 45, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        wave_period = 6;
        watch("b2b_first", 50, 40, 30, 1'b0, 1'b1);
        watch("b2b_second", 20, 30, 40, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            wave_period = $urandom_range(2, 14);
            watch("random", $urandom_range(0, 120), $urandom_range(0, 120),
                  $urandom_range(0, 120), 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_square10();
        test_saturate();
        test_dark();
        test_disturb();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_measure.md
Name: color_measure

Overview:
- Runtime colour reader for the TCS3200-style frequency-output sensor. It is the consumer of the white-balance calibration.
- Inputs are the calibrated per-channel window lengths: para_red, para_green and para_blue, in clk cycles that one white target needs to produce 255 pulses.
- For each filter it counts sensor pulses over that window, which yields 8-bit R/G/B values normalised to white = 255.
- Drives filter_select to the sensor and hands the RGB triplet to the VGA/game logic with a valid pulse.

Parameters:
- CNT_W, 64, width of the calibration inputs and the internal window counter.
- SETTLE_CYC, 1000, clk cycles to wait after each filter change before the window opens (minimum 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin one R/G/B measurement; sampled only in IDLE.
- white_frequency  in  1  raw sensor frequency output; asynchronous to clk.
- para_red  in  CNT_W  red window length in clk cycles.
- para_green  in  CNT_W  green window length in clk cycles.
- para_blue  in  CNT_W  blue window length in clk cycles.
- filter_select  out  2  sensor filter: 00 red, 11 green, 10 blue.
- red  out  8  last measured red value.
- green  out  8  last measured green value.
- blue  out  8  last measured blue value.
- valid  out  1  one-cycle pulse when red/green/blue update.
- busy  out  1  high from the cycle after an accepted start until the DONE cycle inclusive.

Behaviour:
- Reset values (rst high at a clk edge): state IDLE, filter_select=00, red=green=blue=0, valid=0, busy=0, all counters 0, sync flops 0. A reset in any state aborts the measurement, and no partial result is published.
- Input conditioning: white_frequency passes through a 2-flop synchroniser, then a rising-edge detector (registered previous value). A detected edge is a 1-cycle pulse 3 cycles after the raw rise.
- start accepted in IDLE:
  - para_red/green/blue are latched into internal registers; later changes on the inputs are ignored until the next start.
  - busy=1 and filter_select=00; go to SETTLE_R.
- start while busy is ignored, with no queueing.
- Per-channel sequence, for X = R, G, B:
  - SETTLE_X: settle counter runs exactly SETTLE_CYC cycles. Pulses are ignored.
  - MEAS_X: window counter runs exactly para_X cycles. Each edge pulse seen in one of those cycles increments an 8-bit pulse counter, which saturates at 255 and does not wrap.
  - On the last window cycle (an edge there still counts), the pulse count goes into a staging register for channel X and the counter clears.
- Transitions and filter changes:
  - MEAS_R end → SETTLE_G, with filter_select=11 in the same transition.
  - MEAS_G end → SETTLE_B, with filter_select=10.
  - MEAS_B end → DONE.
- Zero window: if latched para_X == 0, MEAS_X lasts 0 cycles. The staged value is 0 and the FSM proceeds directly after SETTLE_X.
- DONE (one cycle): red/green/blue load from staging simultaneously, valid=1, filter_select returns to 00; next state IDLE. busy drops on the cycle after DONE.
- Between measurements, red/green/blue hold their last values.
- Latency from the start edge to valid: 3*SETTLE_CYC + para_red + para_green + para_blue + 1 cycles.
- Arithmetic:
  - Window and settle counters are CNT_W bits, compared by equality against the latched value minus 1, so there is no overflow for any para value.
  - The pulse counter is 8 bits with saturation.
- A start arriving in the same cycle as DONE is ignored; a start one cycle later is accepted.

Decomposition:
- Shared package (colour_pkg):
  - Filter-select constants FILT_RED=2'b00, FILT_GREEN=2'b11, FILT_BLUE=2'b10. The white-balance block shares these.
  - State encoding for IDLE, SETTLE_R, MEAS_R, SETTLE_G, MEAS_G, SETTLE_B, MEAS_B, DONE.
  - WHITE_COUNT=255.
- One natural sub-module, pulse_sync_edge: the 2-flop synchroniser plus rising-edge pulse generator, with its own clk/rst. The same module is reusable by the calibration block.
- The FSM, counters and output registers stay in color_measure.

Test Plan (SETTLE_CYC=4 on the bench):
- Square wave of period 10 clk on white_frequency; para_red=para_green=para_blue=100; pulse start → filter_select goes 00→11→10→00 at the state boundaries, valid one cycle at start+3*4+300+1, red=green=blue=10 (±1 for phase).
- Period 2 clk; para_red=1000, para_green=20, para_blue=0 → red=255 (saturated), green=10, blue=0; valid at start+12+1020+1.
- white_frequency held at 0; para=50 each → red=green=blue=0; valid asserted; busy high for exactly 163 cycles.
- Second start pulsed mid-MEAS_G and para_red changed mid-run → ignored; only one valid; results use the para values latched at the original start.
- rst asserted for one cycle during MEAS_G → next cycle filter_select=00, busy=0, valid=0, outputs 0. No valid follows until a new start, which then completes normally.
- Back-to-back runs: start in the DONE cycle is ignored; start 1 cycle after DONE is accepted; outputs hold the first run's values until the second valid.
